// File: rtl/fetch_ctrl_pkg.sv
// Shared types and helpers for the instruction fetch controller.
package fetch_ctrl_pkg;

  // Fetch sequencer states (3-bit encoding)
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_HOLD   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } fetch_state_e;

  // Instructions are 16 bits wide, so the PC advances by 2 bytes
  localparam logic [15:0] PC_STEP = 16'd2;

  // 16-bit unsigned PC add; the carry out is dropped so the PC wraps
  function automatic logic [15:0] pc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[15:0];
  endfunction

endpackage

// File: rtl/fetch_ctrl_fsm.sv
// Fetch sequencer: tracks the single outstanding imem read, the decode
// handshake, redirect squashing and the terminal halt state.
module fetch_ctrl_fsm
  import fetch_ctrl_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_imem_done,
  input  logic         i_stall,
  input  logic         i_redirect,
  input  logic         i_halt,
  output fetch_state_e o_state,
  output logic         o_valid,
  output logic         o_halted,
  output logic         o_capture,
  output logic         o_load_redirect
);

  fetch_state_e r_state;
  logic         r_valid;
  logic         r_halted;
  logic         w_reading;

  // A read is in flight (or being issued) in FETCH and WAIT
  assign w_reading       = (r_state == ST_FETCH) || (r_state == ST_WAIT);
  // Redirect wins over a completing read: the returned word is thrown away
  assign o_capture       = w_reading && i_imem_done && !i_redirect;
  // Once halted, nothing but reset can move the PC
  assign o_load_redirect = i_redirect && (r_state != ST_HALTED);

  assign o_state  = r_state;
  assign o_valid  = r_valid;
  assign o_halted = r_halted;

  // State register with next-state decode and registered valid/halted flags
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_FETCH;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else if (o_load_redirect) begin
      r_valid <= 1'b0;
      case (r_state)
        // Read completed this cycle or nothing outstanding: refetch immediately
        ST_FETCH, ST_WAIT, ST_DRAIN: r_state <= i_imem_done ? ST_FETCH : ST_DRAIN;
        default:                     r_state <= ST_FETCH;
      endcase
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (i_imem_done) begin
            r_state <= ST_HOLD;
            r_valid <= 1'b1;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_imem_done) begin
            r_state <= ST_HOLD;
            r_valid <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (r_valid && i_halt && !i_stall) begin
            r_state  <= ST_HALTED;
            r_valid  <= 1'b0;
            r_halted <= 1'b1;
          end else if (!i_stall) begin
            r_state <= ST_FETCH;
            r_valid <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (i_imem_done) begin
            r_state <= ST_FETCH;
          end
        end
        ST_HALTED: begin
          r_state <= ST_HALTED;
        end
        default: begin
          r_state <= ST_FETCH;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the PC, talks to a multicycle imem
// with a rd/done handshake and hands instructions to decode.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [15:0] o_imem_addr,
  output logic        o_imem_rd,
  input  logic [15:0] i_imem_data,
  input  logic        i_imem_done,
  input  logic        i_stall_in,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  input  logic        i_halt,
  output logic [15:0] o_instr,
  output logic        o_instr_valid,
  output logic [15:0] o_pc_cur,
  output logic [15:0] o_pc_plus2,
  output logic        o_halted
);

  fetch_state_e w_state;
  logic         w_valid;
  logic         w_capture;
  logic         w_load_redirect;
  logic [15:0]  w_pc_next;

  logic [15:0]  r_pc_q;
  logic [15:0]  r_instr_q;
  logic [15:0]  r_pc_cur;
  logic [15:0]  r_pc_plus2;

  fetch_ctrl_fsm u_fsm (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_imem_done     (i_imem_done),
    .i_stall         (i_stall_in),
    .i_redirect      (i_redirect),
    .i_halt          (i_halt),
    .o_state         (w_state),
    .o_valid         (w_valid),
    .o_halted        (o_halted),
    .o_capture       (w_capture),
    .o_load_redirect (w_load_redirect)
  );

  // Sequential PC; the same sum feeds both the next fetch address and pc_plus2
  assign w_pc_next = pc_add(r_pc_q, PC_STEP);

  // PC and delivered-instruction registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc_q     <= RESET_PC;
      r_instr_q  <= NOP_INSTR;
      r_pc_cur   <= RESET_PC;
      r_pc_plus2 <= pc_add(RESET_PC, PC_STEP);
    end else if (w_load_redirect) begin
      r_pc_q <= i_redirect_pc;
    end else if (w_capture) begin
      r_instr_q  <= i_imem_data;
      r_pc_cur   <= r_pc_q;
      r_pc_plus2 <= w_pc_next;
      r_pc_q     <= w_pc_next;
    end
  end

  // Request is gated by reset so nothing is issued while the state is forced
  assign o_imem_rd     = (w_state == ST_FETCH) && !i_rst;
  assign o_imem_addr   = r_pc_q;
  assign o_instr_valid = w_valid;
  assign o_instr       = w_valid ? r_instr_q : NOP_INSTR;
  assign o_pc_cur      = r_pc_cur;
  assign o_pc_plus2    = r_pc_plus2;

endmodule
